dbus_route_unit: RTL and testbench



---
 rtl/dbus_route_unit.sv | 157 +++++++++++++++
 tb/tb_dbus_route_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_route_unit.sv
// dbus_route_unit: steers one CPU data-bus request at a time to either the
// data-cache port or the uncached bus port and returns that port's response.
// It also has a hang watchdog and an uncached-access counter for debug.
module dbus_route_unit #(
  parameter int HANG_LIMIT = 1023,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             creq_valid,
  input  logic [31:0]      creq_paddr,
  input  logic             creq_uncached,
  input  logic [3:0]       creq_strobe,
  input  logic [2:0]       creq_size,
  input  logic [31:0]      creq_wdata,
  output logic             cresp_addr_ok,
  output logic             cresp_data_ok,
  output logic [31:0]      cresp_rdata,
  output logic             dc_valid,
  output logic [31:0]      dc_paddr,
  output logic [3:0]       dc_strobe,
  output logic [2:0]       dc_size,
  output logic [31:0]      dc_wdata,
  input  logic             dc_data_ok,
  input  logic [31:0]      dc_rdata,
  output logic             uc_valid,
  output logic [31:0]      uc_paddr,
  output logic [3:0]       uc_strobe,
  output logic [2:0]       uc_size,
  output logic [31:0]      uc_wdata,
  input  logic             uc_data_ok,
  input  logic [31:0]      uc_rdata,
  output logic             hang_flag,
  output logic [CNT_W-1:0] uc_count
);

  // FWD_C / FWD_U also serve as the latched "uncached" bit of the request.
  typedef enum logic [1:0] {IDLE, FWD_C, FWD_U, RESP} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       paddr_reg, wdata_reg, rdata_reg;
  logic [3:0]        strobe_reg;
  logic [2:0]        size_reg;
  logic [CNT_W-1:0]  uc_count_reg;
  logic              accept, fwd, sel_ok;
  logic [31:0]       sel_rdata;

  // Acceptance is suppressed while reset is asserted so addr_ok never lies.
  assign accept    = (state_reg == IDLE) && creq_valid && resetn;
  assign fwd       = (state_reg == FWD_C) || (state_reg == FWD_U);
  // Only the selected port's completion counts; the other port is ignored.
  assign sel_ok    = ((state_reg == FWD_C) && dc_data_ok) ||
                     ((state_reg == FWD_U) && uc_data_ok);
  assign sel_rdata = (state_reg == FWD_U) ? uc_rdata : dc_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic and CPU/downstream handshake outputs.
  always_comb begin
    state_next    = state_reg;
    cresp_addr_ok = 1'b0;
    cresp_data_ok = 1'b0;
    dc_valid      = 1'b0;
    uc_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        cresp_addr_ok = accept;
        if (accept) state_next = creq_uncached ? FWD_U : FWD_C;
      end
      FWD_C: begin
        dc_valid = 1'b1;
        if (sel_ok) state_next = RESP;
      end
      FWD_U: begin
        uc_valid = 1'b1;
        if (sel_ok) state_next = RESP;
      end
      RESP: begin
        cresp_data_ok = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request field latch, loaded only on acceptance so downstream fields stay stable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      paddr_reg  <= '0;
      strobe_reg <= '0;
      size_reg   <= '0;
      wdata_reg  <= '0;
    end else if (accept) begin
      paddr_reg  <= creq_paddr;
      strobe_reg <= creq_strobe;
      size_reg   <= creq_size;
      wdata_reg  <= creq_wdata;
    end
  end

  // Response capture; writes return zero regardless of what the port drives.
  always_ff @(posedge clk) begin
    if (!resetn)     rdata_reg <= '0;
    else if (sel_ok) rdata_reg <= (strobe_reg != 4'd0) ? 32'd0 : sel_rdata;
  end

  // Wrapping count of accepted uncached requests.
  always_ff @(posedge clk) begin
    if (!resetn)                      uc_count_reg <= '0;
    else if (accept && creq_uncached) uc_count_reg <= uc_count_reg + CNT_W'(1);
  end

  assign cresp_rdata = rdata_reg;
  assign uc_count    = uc_count_reg;
  assign dc_paddr    = paddr_reg;
  assign dc_strobe   = strobe_reg;
  assign dc_size     = size_reg;
  assign dc_wdata    = wdata_reg;
  assign uc_paddr    = paddr_reg;
  assign uc_strobe   = strobe_reg;
  assign uc_size     = size_reg;
  assign uc_wdata    = wdata_reg;

  generate
    if (HANG_LIMIT > 0) begin : g_wd
      localparam int WD_W = $clog2(HANG_LIMIT + 1);
      localparam logic [WD_W-1:0] WD_MAX = WD_W'(HANG_LIMIT);
      logic [WD_W-1:0] wd_cnt_reg;
      logic [WD_W-1:0] wd_inc;
      logic            hang_reg;

      assign wd_inc = wd_cnt_reg + WD_W'(1);

      // Watchdog: counts forwarding cycles (saturating), flag is sticky until reset.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          wd_cnt_reg <= '0;
          hang_reg   <= 1'b0;
        end else if (accept) begin
          wd_cnt_reg <= '0;
        end else if (fwd) begin
          if (wd_cnt_reg != WD_MAX) wd_cnt_reg <= wd_inc;
          if (wd_inc == WD_MAX)     hang_reg   <= 1'b1;
        end
      end

      assign hang_flag = hang_reg;
    end else begin : g_no_wd
      assign hang_flag = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dbus_route_unit.sv
// Directed testbench for dbus_route_unit (HANG_LIMIT=8, CNT_W=2).
module tb_dbus_route_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        creq_valid;
  logic [31:0] creq_paddr;
  logic        creq_uncached;
  logic [3:0]  creq_strobe;
  logic [2:0]  creq_size;
  logic [31:0] creq_wdata;
  logic        cresp_addr_ok, cresp_data_ok;
  logic [31:0] cresp_rdata;
  logic        dc_valid, uc_valid;
  logic [31:0] dc_paddr, uc_paddr, dc_wdata, uc_wdata;
  logic [3:0]  dc_strobe, uc_strobe;
  logic [2:0]  dc_size, uc_size;
  logic        dc_data_ok, uc_data_ok;
  logic [31:0] dc_rdata, uc_rdata;
  logic        hang_flag;
  logic [1:0]  uc_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] uc_seq [5] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

  dbus_route_unit #(.HANG_LIMIT(8), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .creq_valid(creq_valid), .creq_paddr(creq_paddr), .creq_uncached(creq_uncached),
    .creq_strobe(creq_strobe), .creq_size(creq_size), .creq_wdata(creq_wdata),
    .cresp_addr_ok(cresp_addr_ok), .cresp_data_ok(cresp_data_ok), .cresp_rdata(cresp_rdata),
    .dc_valid(dc_valid), .dc_paddr(dc_paddr), .dc_strobe(dc_strobe), .dc_size(dc_size),
    .dc_wdata(dc_wdata), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .uc_valid(uc_valid), .uc_paddr(uc_paddr), .uc_strobe(uc_strobe), .uc_size(uc_size),
    .uc_wdata(uc_wdata), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata),
    .hang_flag(hang_flag), .uc_count(uc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] pa, input logic unc, input logic [3:0] stb,
                         input logic [31:0] wd);
    creq_valid    = 1'b1;
    creq_paddr    = pa;
    creq_uncached = unc;
    creq_strobe   = stb;
    creq_size     = 3'd2;
    creq_wdata    = wd;
  endtask

  task automatic idle_creq();
    creq_valid    = 1'b0;
    creq_paddr    = 32'h0;
    creq_uncached = 1'b0;
    creq_strobe   = 4'h0;
    creq_size     = 3'd0;
    creq_wdata    = 32'h0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_creq();
    dc_data_ok = 1'b0; dc_rdata = 32'h0;
    uc_data_ok = 1'b0; uc_rdata = 32'h0;
    cyc(); cyc();
    #1;
    check("rst addr_ok", 32'(cresp_addr_ok), 32'd0);
    check("rst data_ok", 32'(cresp_data_ok), 32'd0);
    check("rst dc_valid", 32'(dc_valid), 32'd0);
    check("rst uc_valid", 32'(uc_valid), 32'd0);
    check("rst dc_paddr", dc_paddr, 32'd0);
    check("rst hang", 32'(hang_flag), 32'd0);
    check("rst uc_count", 32'(uc_count), 32'd0);
    resetn = 1'b1;
    cyc();

    // Cached read
    request(32'h1FC0_0000, 1'b0, 4'h0, 32'h0);
    #1 check("cr addr_ok", 32'(cresp_addr_ok), 32'd1);
    cyc();
    idle_creq();
    dc_data_ok = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    #1 check("cr dc_valid", 32'(dc_valid), 32'd1);
    check("cr uc_valid", 32'(uc_valid), 32'd0);
    check("cr dc_paddr", dc_paddr, 32'h1FC0_0000);
    check("cr dc_size", 32'(dc_size), 32'd2);
    check("cr addr_ok fwd", 32'(cresp_addr_ok), 32'd0);
    cyc();
    dc_data_ok = 1'b0; dc_rdata = 32'h0;
    #1 check("cr data_ok", 32'(cresp_data_ok), 32'd1);
    check("cr rdata", cresp_rdata, 32'hDEAD_BEEF);
    check("cr dc_valid resp", 32'(dc_valid), 32'd0);
    check("cr uc_count", 32'(uc_count), 32'd0);
    cyc();
    #1 check("cr data_ok after", 32'(cresp_data_ok), 32'd0);
    check("cr rdata hold", cresp_rdata, 32'hDEAD_BEEF);
    $display("txn cached read pa=1fc00000 rdata=%h", cresp_rdata);

    // Uncached write, 5 wait cycles
    request(32'h1FAF_0000, 1'b1, 4'hF, 32'h1234_5678);
    #1 check("uw addr_ok", 32'(cresp_addr_ok), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      idle_creq();
      if (i == 6) begin uc_data_ok = 1'b1; uc_rdata = 32'hAAAA_5555; end
      #1 check("uw uc_valid", 32'(uc_valid), 32'd1);
      check("uw dc_valid", 32'(dc_valid), 32'd0);
      check("uw uc_paddr", uc_paddr, 32'h1FAF_0000);
      check("uw uc_strobe", 32'(uc_strobe), 32'hF);
      check("uw uc_wdata", uc_wdata, 32'h1234_5678);
    end
    cyc();
    uc_data_ok = 1'b0; uc_rdata = 32'h0;
    #1 check("uw data_ok", 32'(cresp_data_ok), 32'd1);
    check("uw rdata", cresp_rdata, 32'h0);
    check("uw uc_count", 32'(uc_count), 32'd1);
    check("uw hang", 32'(hang_flag), 32'd0);
    $display("txn uncached write pa=1faf0000 rdata=%h", cresp_rdata);
    cyc();

    // Back-to-back: cached read then uncached read
    request(32'h0000_1000, 1'b0, 4'h0, 32'h0);
    #1 check("bb1 addr_ok", 32'(cresp_addr_ok), 32'd1);
    cyc();
    idle_creq();
    dc_data_ok = 1'b1; dc_rdata = 32'h1111_2222;
    #1 check("bb1 dc_valid", 32'(dc_valid), 32'd1);
    check("bb1 uc_valid", 32'(uc_valid), 32'd0);
    cyc();
    dc_data_ok = 1'b0; dc_rdata = 32'h0;
    request(32'hBFD0_0010, 1'b1, 4'h0, 32'h0);
    #1 check("bb1 data_ok", 32'(cresp_data_ok), 32'd1);
    check("bb1 rdata", cresp_rdata, 32'h1111_2222);
    check("bb resp addr_ok", 32'(cresp_addr_ok), 32'd0);
    $display("txn b2b cached read rdata=%h", cresp_rdata);
    cyc();
    #1 check("bb2 addr_ok", 32'(cresp_addr_ok), 32'd1);
    check("bb2 data_ok idle", 32'(cresp_data_ok), 32'd0);
    check("bb idle dc_valid", 32'(dc_valid), 32'd0);
    check("bb idle uc_valid", 32'(uc_valid), 32'd0);
    cyc();
    idle_creq();
    uc_data_ok = 1'b1; uc_rdata = 32'hCAFE_F00D;
    #1 check("bb2 uc_valid", 32'(uc_valid), 32'd1);
    check("bb2 dc_valid", 32'(dc_valid), 32'd0);
    check("bb2 uc_paddr", uc_paddr, 32'hBFD0_0010);
    cyc();
    uc_data_ok = 1'b0; uc_rdata = 32'h0;
    #1 check("bb2 data_ok", 32'(cresp_data_ok), 32'd1);
    check("bb2 rdata", cresp_rdata, 32'hCAFE_F00D);
    check("bb2 uc_count", 32'(uc_count), 32'd2);
    $display("txn b2b uncached read rdata=%h", cresp_rdata);
    cyc();

    // Watchdog: uncached request left unanswered
    request(32'h1FD0_0000, 1'b1, 4'h0, 32'h0);
    #1 check("wd addr_ok", 32'(cresp_addr_ok), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      idle_creq();
      if (i == 12) begin uc_data_ok = 1'b1; uc_rdata = 32'h0BAD_F00D; end
      #1 check("wd uc_valid", 32'(uc_valid), 32'd1);
      check("wd hang", 32'(hang_flag), (i <= 8) ? 32'd0 : 32'd1);
    end
    cyc();
    uc_data_ok = 1'b0; uc_rdata = 32'h0;
    #1 check("wd data_ok", 32'(cresp_data_ok), 32'd1);
    check("wd rdata", cresp_rdata, 32'h0BAD_F00D);
    check("wd uc_count", 32'(uc_count), 32'd3);
    cyc();
    #1 check("wd hang sticky", 32'(hang_flag), 32'd1);
    check("wd data_ok after", 32'(cresp_data_ok), 32'd0);
    $display("txn watchdog uncached read rdata=0badf00d hang=%0d", hang_flag);

    // Reset while in FWD_C
    request(32'h0000_2000, 1'b0, 4'h3, 32'h55AA_55AA);
    cyc();
    idle_creq();
    resetn = 1'b0;
    #1 check("rm dc_valid", 32'(dc_valid), 32'd1);
    cyc();
    resetn = 1'b1;
    #1 check("rm dc_valid", 32'(dc_valid), 32'd0);
    check("rm uc_valid", 32'(uc_valid), 32'd0);
    check("rm dc_paddr", dc_paddr, 32'd0);
    check("rm dc_strobe", 32'(dc_strobe), 32'd0);
    check("rm dc_wdata", dc_wdata, 32'd0);
    check("rm uc_paddr", uc_paddr, 32'd0);
    check("rm hang", 32'(hang_flag), 32'd0);
    check("rm uc_count", 32'(uc_count), 32'd0);
    check("rm data_ok", 32'(cresp_data_ok), 32'd0);
    check("rm rdata", cresp_rdata, 32'd0);
    check("rm addr_ok", 32'(cresp_addr_ok), 32'd0);
    request(32'h0000_3000, 1'b0, 4'h0, 32'h0);
    #1 check("rm new addr_ok", 32'(cresp_addr_ok), 32'd1);
    cyc();
    idle_creq();
    dc_data_ok = 1'b1; dc_rdata = 32'h7654_3210;
    #1 check("rm new dc_valid", 32'(dc_valid), 32'd1);
    check("rm new dc_paddr", dc_paddr, 32'h0000_3000);
    cyc();
    dc_data_ok = 1'b0; dc_rdata = 32'h0;
    #1 check("rm new data_ok", 32'(cresp_data_ok), 32'd1);
    check("rm new rdata", cresp_rdata, 32'h7654_3210);
    $display("txn post-reset cached read rdata=%h", cresp_rdata);
    cyc();

    // Counter wrap with stray dc_data_ok during FWD_U
    for (int i = 0; i < 5; i++) begin
      request(32'h1FE0_0000 + 32'(i * 4), 1'b1, 4'h0, 32'h0);
      #1 check("wr addr_ok", 32'(cresp_addr_ok), 32'd1);
      cyc();
      idle_creq();
      dc_data_ok = 1'b1; dc_rdata = 32'hFFFF_FFFF;
      #1 check("wr uc_valid", 32'(uc_valid), 32'd1);
      check("wr dc_valid", 32'(dc_valid), 32'd0);
      cyc();
      dc_data_ok = 1'b0; dc_rdata = 32'h0;
      uc_data_ok = 1'b1; uc_rdata = 32'h100 + 32'(i);
      #1 check("wr stray ignored", 32'(uc_valid), 32'd1);
      check("wr no early resp", 32'(cresp_data_ok), 32'd0);
      cyc();
      uc_data_ok = 1'b0; uc_rdata = 32'h0;
      #1 check("wr data_ok", 32'(cresp_data_ok), 32'd1);
      check("wr rdata", cresp_rdata, 32'h100 + 32'(i));
      check("wr uc_count", 32'(uc_count), uc_seq[i]);
      $display("txn wrap uncached read %0d rdata=%h uc_count=%0d", i, cresp_rdata, uc_count);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
